// File: rtl/univ_shift_reg_pkg.sv
// Shared flip-flop library package: operation-mode encodings and the burst
// state enum used by the universal shift register and its burst controller.
package univ_shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } burst_state_e;

    // Only the two shift modes may launch a burst; other modes ignore start.
    function automatic logic isShiftMode(input logic [1:0] m);
        return (m == MODE_SHR) || (m == MODE_SHL);
    endfunction

endpackage

// File: rtl/univ_shift_reg_burst_ctrl.sv
// shift_burst_ctrl: burst state machine and down-counter. It latches the shift
// direction on a start request and requests one shift per enabled edge.
import univ_shift_reg_pkg::*;

module shift_burst_ctrl #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             shift_en,
    output logic             shift_dir,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO = '0;

    burst_state_e     state_q;
    logic [CNT_W-1:0] rem_q;
    logic             dir_q;

    // dir_q: 0 = shift right, 1 = shift left.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            rem_q   <= ZERO;
            dir_q   <= 1'b0;
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    if (start && isShiftMode(mode)) begin
                        dir_q   <= (mode == MODE_SHL);
                        rem_q   <= count;
                        state_q <= (count == ZERO) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    rem_q <= rem_q - ONE;
                    if (rem_q == ONE) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign shift_en  = en && (state_q == BUSY);
    assign shift_dir = dir_q;
    assign busy      = (state_q == BUSY);
    assign done      = (state_q == DONE);

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register (hold/shr/shl/load) with
// an autonomous burst mode. Define ROTATE_EN to make shifts rotate instead of
// taking sin_r/sin_l.
import univ_shift_reg_pkg::*;

module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] D,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] Q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] shrVal;
    logic [WIDTH-1:0] shlVal;
    logic             fillR;
    logic             fillL;
    logic             shiftEn;
    logic             shiftDir;
    logic             burstReq;
    logic             idle;

    shift_burst_ctrl #(
        .CNT_W(CNT_W)
    ) u_ctrl (
        .clk      (clk),
        .clear    (clear),
        .en       (en),
        .mode     (mode),
        .start    (start),
        .count    (count),
        .shift_en (shiftEn),
        .shift_dir(shiftDir),
        .busy     (busy),
        .done     (done)
    );

`ifdef ROTATE_EN
    assign fillR = q_q[0];
    assign fillL = q_q[WIDTH-1];
`else
    assign fillR = sin_r;
    assign fillL = sin_l;
`endif

    assign shrVal   = {fillR, q_q[WIDTH-1:1]};
    assign shlVal   = {q_q[WIDTH-2:0], fillL};
    assign burstReq = start && isShiftMode(mode);
    assign idle     = !busy && !done;

    // Manual modes run only in IDLE and not on the edge that launches a burst.
    always_comb begin
        q_d = q_q;
        if (shiftEn) begin
            q_d = shiftDir ? shlVal : shrVal;
        end else if (en && idle && !burstReq) begin
            case (mode)
                MODE_SHR:  q_d = shrVal;
                MODE_SHL:  q_d = shlVal;
                MODE_LOAD: q_d = D;
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q      = q_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg; expected values go through
// a scoreboard queue. Expectations adapt when ROTATE_EN is defined.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       clear, en, start, sin_r, sin_l;
    logic [1:0] mode;
    logic [7:0] D;
    logic [3:0] count;
    logic [7:0] Q;
    logic       sout_r, sout_l, busy, done;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } expect_t;

    expect_t sb[$];
    int      testsRun  = 0;
    int      testsFail = 0;
    int      busyCycles;

    univ_shift_reg #(.WIDTH(8)) dut (
        .clk   (clk),
        .clear (clear),
        .en    (en),
        .mode  (mode),
        .sin_r (sin_r),
        .sin_l (sin_l),
        .D     (D),
        .start (start),
        .count (count),
        .Q     (Q),
        .sout_r(sout_r),
        .sout_l(sout_l),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Drive all inputs, then advance one rising edge and settle before sampling.
    task automatic applyStimulus(input logic clr, input logic e, input logic [1:0] m,
                                 input logic [7:0] d, input logic st, input logic [3:0] cnt,
                                 input logic sr, input logic sl);
        clear = clr;
        en    = e;
        mode  = m;
        D     = d;
        start = st;
        count = cnt;
        sin_r = sr;
        sin_l = sl;
        @(posedge clk);
        #1;
    endtask

    task automatic expectValue(input string tag, input logic [31:0] v);
        expect_t item;
        item.tag   = tag;
        item.value = v;
        sb.push_back(item);
    endtask

    // Pop the oldest expectation and compare it with the observed value.
    task automatic checkOutput(input logic [31:0] observed);
        expect_t item;
        testsRun++;
        if (sb.size() == 0) begin
            testsFail++;
            $display("[TB] FAIL scoreboard-empty: observed %0h required an expectation", observed);
        end else begin
            item = sb.pop_front();
            assert (observed === item.value) else begin
                testsFail++;
                $error("[TB] FAIL %s: observed %0h expected %0h", item.tag, observed, item.value);
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state.
        applyStimulus(1, 0, 2'b00, 8'h00, 0, 4'd0, 0, 0);
        expectValue("reset Q", 8'h00);    checkOutput(Q);
        expectValue("reset busy", 0);     checkOutput(busy);
        expectValue("reset done", 0);     checkOutput(done);

        // Load A5, then clear with en low and a load pending.
        applyStimulus(0, 1, 2'b11, 8'hA5, 0, 4'd0, 0, 0);
        expectValue("load A5", 8'hA5);    checkOutput(Q);
        applyStimulus(1, 0, 2'b11, 8'hFF, 1, 4'd3, 0, 0);
        expectValue("clear Q", 8'h00);    checkOutput(Q);
        expectValue("clear busy", 0);     checkOutput(busy);
        expectValue("clear done", 0);     checkOutput(done);

        // Manual shifts.
        applyStimulus(0, 1, 2'b11, 8'h81, 0, 4'd0, 0, 0);
        expectValue("load 81", 8'h81);    checkOutput(Q);
        applyStimulus(0, 1, 2'b01, 8'h00, 0, 4'd0, 0, 0);
`ifdef ROTATE_EN
        expectValue("shr Q", 8'hC0);
        expectValue("shr sout_l", 1);
`else
        expectValue("shr Q", 8'h40);
        expectValue("shr sout_l", 0);
`endif
        checkOutput(Q);
        checkOutput(sout_l);
        expectValue("shr sout_r", 0);     checkOutput(sout_r);
        applyStimulus(0, 1, 2'b10, 8'h00, 0, 4'd0, 0, 1);
        expectValue("shl1 Q", 8'h81);     checkOutput(Q);
        expectValue("shl1 sout_r", 1);    checkOutput(sout_r);
        applyStimulus(0, 1, 2'b10, 8'h00, 0, 4'd0, 0, 1);
        expectValue("shl2 Q", 8'h03);     checkOutput(Q);
        applyStimulus(0, 1, 2'b00, 8'hEE, 0, 4'd0, 1, 1);
        expectValue("hold Q", 8'h03);     checkOutput(Q);

        // Burst right by 3; mode/D changes during the burst must be ignored.
        applyStimulus(0, 1, 2'b11, 8'hF0, 0, 4'd0, 0, 0);
        expectValue("load F0", 8'hF0);    checkOutput(Q);
        applyStimulus(0, 1, 2'b01, 8'h00, 1, 4'd3, 0, 0);
        expectValue("burst start Q", 8'hF0); checkOutput(Q);
        busyCycles = busy ? 1 : 0;
        for (int i = 0; i < 20 && busy; i++) begin
            applyStimulus(0, 1, 2'b11, 8'hFF, 0, 4'd0, 0, 0);
            if (busy) busyCycles++;
        end
        expectValue("burst3 busy cycles", 3); checkOutput(busyCycles);
        expectValue("burst3 done", 1);        checkOutput(done);
        expectValue("burst3 Q", 8'h1E);       checkOutput(Q);
        applyStimulus(0, 1, 2'b00, 8'h00, 0, 4'd0, 0, 0);
        expectValue("burst3 done drop", 0);   checkOutput(done);
        expectValue("burst3 idle busy", 0);   checkOutput(busy);

        // Burst with count 0, then start with load mode.
        applyStimulus(0, 1, 2'b10, 8'h00, 1, 4'd0, 1, 1);
        expectValue("cnt0 done", 1);      checkOutput(done);
        expectValue("cnt0 busy", 0);      checkOutput(busy);
        expectValue("cnt0 Q", 8'h1E);     checkOutput(Q);
        applyStimulus(0, 1, 2'b00, 8'h00, 0, 4'd0, 0, 0);
        expectValue("cnt0 done drop", 0); checkOutput(done);
        applyStimulus(0, 1, 2'b11, 8'h3C, 1, 4'd5, 0, 0);
        expectValue("start+load Q", 8'h3C); checkOutput(Q);
        expectValue("start+load busy", 0);  checkOutput(busy);
        applyStimulus(0, 1, 2'b00, 8'h00, 0, 4'd0, 0, 0);
        expectValue("start+load busy2", 0); checkOutput(busy);
        expectValue("start+load done", 0);  checkOutput(done);

        // Burst left by 4 with a two-cycle en stall after the first shift.
        applyStimulus(0, 1, 2'b10, 8'h00, 1, 4'd4, 0, 1);
        busyCycles = busy ? 1 : 0;
        applyStimulus(0, 1, 2'b00, 8'h00, 0, 4'd0, 0, 1);
        if (busy) busyCycles++;
        applyStimulus(0, 0, 2'b00, 8'h00, 0, 4'd0, 0, 1);
        if (busy) busyCycles++;
        applyStimulus(0, 0, 2'b00, 8'h00, 0, 4'd0, 0, 1);
        if (busy) busyCycles++;
        for (int i = 0; i < 20 && busy; i++) begin
            applyStimulus(0, 1, 2'b00, 8'h00, 0, 4'd0, 0, 1);
            if (busy) busyCycles++;
        end
        expectValue("stall busy cycles", 6); checkOutput(busyCycles);
        expectValue("stall done", 1);        checkOutput(done);
`ifdef ROTATE_EN
        expectValue("stall Q", 8'hC3);
`else
        expectValue("stall Q", 8'hCF);
`endif
        checkOutput(Q);
        applyStimulus(0, 1, 2'b00, 8'h00, 0, 4'd0, 0, 0);

        // Abort a burst with clear: no done pulse, back to IDLE.
        applyStimulus(0, 1, 2'b01, 8'h00, 1, 4'd5, 0, 0);
        applyStimulus(0, 1, 2'b00, 8'h00, 0, 4'd0, 0, 0);
        applyStimulus(0, 1, 2'b00, 8'h00, 0, 4'd0, 0, 0);
        expectValue("abort pre busy", 1); checkOutput(busy);
        applyStimulus(1, 1, 2'b00, 8'h00, 0, 4'd0, 0, 0);
        expectValue("abort Q", 8'h00);    checkOutput(Q);
        expectValue("abort busy", 0);     checkOutput(busy);
        expectValue("abort done", 0);     checkOutput(done);
        applyStimulus(0, 1, 2'b00, 8'h00, 0, 4'd0, 0, 0);
        expectValue("abort no done", 0);  checkOutput(done);
        applyStimulus(0, 1, 2'b11, 8'h55, 0, 4'd0, 0, 0);
        expectValue("abort idle load", 8'h55); checkOutput(Q);

        // Long burst left by 9 (exceeds width).
        applyStimulus(0, 1, 2'b11, 8'h01, 0, 4'd0, 0, 0);
        applyStimulus(0, 1, 2'b10, 8'h00, 1, 4'd9, 0, 1);
        for (int i = 0; i < 30 && !done; i++) begin
            applyStimulus(0, 1, 2'b00, 8'h00, 0, 4'd0, 0, 1);
        end
        expectValue("burst9 done", 1);    checkOutput(done);
`ifdef ROTATE_EN
        expectValue("burst9 Q", 8'h02);
`else
        expectValue("burst9 Q", 8'hFF);
`endif
        checkOutput(Q);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
